// File: rtl/hrfp_align_add.sv
// Alignment and mantissa add/subtract stages of the radix-16 floating-point adder.
// Define HRFP_INPUT_REG_EN to add an input register stage (latency 3 instead of 2).
module hrfp_align_add #(
  parameter  int EXP_W = 6,
  parameter  int MAN_W = 27,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     op2_a,
  input  logic [W-1:0]     op2_b,
  input  logic [2:0]       expdiff_2,
  input  logic             expdiff_saturated_2,
  output logic             out_valid,
  output logic [W-1:0]     result_4,
  output logic [MAN_W+3:0] mantissa_4,
  output logic [7:0]       zeroesmask_4
);

  localparam int EB_W  = MAN_W + 3;
  localparam int SUM_W = MAN_W + 4;
  localparam int NIB   = (SUM_W + 1) / 4;

  logic [W-1:0] s0_a, s0_b;
  logic [2:0]   s0_diff;
  logic         s0_sat, s0_valid;

`ifdef HRFP_INPUT_REG_EN
  logic [W-1:0] in_a_q, in_a_d, in_b_q, in_b_d;
  logic [2:0]   in_diff_q, in_diff_d;
  logic         in_sat_q, in_sat_d, in_valid_q, in_valid_d;

  always_comb begin
    in_a_d     = op2_a;
    in_b_d     = op2_b;
    in_diff_d  = expdiff_2;
    in_sat_d   = expdiff_saturated_2;
    in_valid_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_a_q     <= '0;
      in_b_q     <= '0;
      in_diff_q  <= '0;
      in_sat_q   <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      in_a_q     <= in_a_d;
      in_b_q     <= in_b_d;
      in_diff_q  <= in_diff_d;
      in_sat_q   <= in_sat_d;
      in_valid_q <= in_valid_d;
    end
  end

  assign s0_a     = in_a_q;
  assign s0_b     = in_b_q;
  assign s0_diff  = in_diff_q;
  assign s0_sat   = in_sat_q;
  assign s0_valid = in_valid_q;
`else
  assign s0_a     = op2_a;
  assign s0_b     = op2_b;
  assign s0_diff  = expdiff_2;
  assign s0_sat   = expdiff_saturated_2;
  assign s0_valid = in_valid;
`endif

  // Stage 1: pre-compute both candidate alignments; the low half of each
  // double-width shift holds the bits that fall off and become the sticky bit.
  logic [EB_W-1:0]   eb;
  logic [2*EB_W-1:0] ext0, ext1;
  logic [EB_W-1:0]   align0_d, align0_q, align1_d, align1_q;
  logic [W-1:0]      op_a_d, op_a_q, op_b_d, op_b_q;
  logic              expdiff_msb_d, expdiff_msb_q;
  logic              valid1_d, valid1_q;

  always_comb begin
    eb            = {s0_b[MAN_W-1:0], 3'b000};
    ext0          = {eb, {EB_W{1'b0}}} >> {1'b0, s0_diff[1:0], 2'b00};
    ext1          = {eb, {EB_W{1'b0}}} >> {1'b1, s0_diff[1:0], 2'b00};
    align0_d      = ext0[2*EB_W-1:EB_W] | {{(EB_W-1){1'b0}}, |ext0[EB_W-1:0]};
    align1_d      = ext1[2*EB_W-1:EB_W] | {{(EB_W-1){1'b0}}, |ext1[EB_W-1:0]};
    if (s0_sat) begin
      align0_d = {{(EB_W-1){1'b0}}, |s0_b[MAN_W-1:0]};
      align1_d = {{(EB_W-1){1'b0}}, |s0_b[MAN_W-1:0]};
    end
    op_a_d        = s0_a;
    op_b_d        = s0_b;
    expdiff_msb_d = s0_diff[2];
    valid1_d      = s0_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      align0_q      <= '0;
      align1_q      <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      expdiff_msb_q <= 1'b0;
      valid1_q      <= 1'b0;
    end else begin
      align0_q      <= align0_d;
      align1_q      <= align1_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      expdiff_msb_q <= expdiff_msb_d;
      valid1_q      <= valid1_d;
    end
  end

  // Stage 2: add/subtract, then let specials override the arithmetic result.
  logic [EB_W-1:0]  b_al;
  logic [SUM_W-1:0] ea, sum;
  logic [SUM_W:0]   padded;
  logic             same_sign, a_special, b_special, a_inf, b_inf;
  logic [W-1:0]     result_d, result_q;
  logic [SUM_W-1:0] mantissa_d, mantissa_q;
  logic [7:0]       zmask_d, zmask_q;
  logic             valid2_d, valid2_q;

  always_comb begin
    b_al      = expdiff_msb_q ? align1_q : align0_q;
    ea        = {1'b0, op_a_q[MAN_W-1:0], 3'b000};
    same_sign = (op_a_q[W-1] == op_b_q[W-1]);
    sum       = same_sign ? (ea + {1'b0, b_al}) : (ea - {1'b0, b_al});
    a_special = &op_a_q[W-2:MAN_W];
    b_special = &op_b_q[W-2:MAN_W];
    a_inf     = a_special && (op_a_q[MAN_W-1:0] == '0);
    b_inf     = b_special && (op_b_q[MAN_W-1:0] == '0);

    result_d   = op_a_q;
    mantissa_d = sum;
    if (!same_sign && (sum == '0)) begin
      result_d[W-1] = 1'b0;
    end
    if (a_special) begin
      result_d   = op_a_q;
      mantissa_d = '0;
      if (a_inf && b_inf && !same_sign) begin
        result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      end
    end

    padded  = {1'b0, mantissa_d};
    zmask_d = '0;
    for (int i = 0; i < NIB; i++) begin
      zmask_d[i] = ~|padded[4*i +: 4];
    end
    valid2_d = valid1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      mantissa_q <= '0;
      zmask_q    <= '0;
      valid2_q   <= 1'b0;
    end else begin
      result_q   <= result_d;
      mantissa_q <= mantissa_d;
      zmask_q    <= zmask_d;
      valid2_q   <= valid2_d;
    end
  end

  assign out_valid    = valid2_q;
  assign result_4     = result_q;
  assign mantissa_4   = mantissa_q;
  assign zeroesmask_4 = zmask_q;

endmodule

// File: tb/tb_hrfp_align_add.sv
// Directed self-checking bench for hrfp_align_add: reset state, streamed vectors
// with hand-computed results, and reset in the middle of a stream.
module tb_hrfp_align_add;

`ifdef HRFP_INPUT_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif
   localparam int N = 10;

   logic        clock = 1'b0;
   logic        rst;
   logic        inValid;
   logic [33:0] opA, opB;
   logic [2:0]  expDiff;
   logic        expSat;
   logic        outValid;
   logic [33:0] result;
   logic [30:0] mantissa;
   logic [7:0]  zeroMask;

   int checkCount = 0;
   int errorCount = 0;

   logic [33:0] vecA    [N];
   logic [33:0] vecB    [N];
   logic [2:0]  vecDiff [N];
   logic        vecSat  [N];
   logic [33:0] expRes  [N];
   logic [30:0] expMan  [N];
   logic [7:0]  expMask [N];

   hrfp_align_add dut (
      .clk                 (clock),
      .rst                 (rst),
      .in_valid            (inValid),
      .op2_a               (opA),
      .op2_b               (opB),
      .expdiff_2           (expDiff),
      .expdiff_saturated_2 (expSat),
      .out_valid           (outValid),
      .result_4            (result),
      .mantissa_4          (mantissa),
      .zeroesmask_4        (zeroMask)
   );

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one set of inputs; called right after a falling edge.
   task automatic applyStimulus(input logic v, input logic [33:0] a, input logic [33:0] b,
                                input logic [2:0] d, input logic s);
      inValid = v;
      opA     = a;
      opB     = b;
      expDiff = d;
      expSat  = s;
   endtask

   // Compares all outputs of one vector against its hand-computed values.
   task automatic checkVector(input int i);
      checkOutput($sformatf("v%0d valid", i), 64'(outValid), 64'(1'b1));
      checkOutput($sformatf("v%0d result", i), 64'(result), 64'(expRes[i]));
      checkOutput($sformatf("v%0d mantissa", i), 64'(mantissa), 64'(expMan[i]));
      checkOutput($sformatf("v%0d zmask", i), 64'(zeroMask), 64'(expMask[i]));
   endtask

   // Checks that every output sits at its cleared value.
   task automatic checkCleared(input string tag);
      checkOutput({tag, " valid"}, 64'(outValid), 64'(1'b0));
      checkOutput({tag, " result"}, 64'(result), 64'(0));
      checkOutput({tag, " mantissa"}, 64'(mantissa), 64'(0));
      checkOutput({tag, " zmask"}, 64'(zeroMask), 64'(0));
   endtask

   // Hand-computed vector table.
   initial begin
      // equal exponents add
      vecA[0] = {1'b0, 6'h20, 27'h1000000}; vecB[0] = {1'b0, 6'h20, 27'h1000000};
      vecDiff[0] = 3'd0; vecSat[0] = 1'b0;
      expRes[0] = vecA[0]; expMan[0] = 31'h10000000; expMask[0] = 8'h7F;
      // one-nibble shift with sticky
      vecA[1] = {1'b0, 6'h20, 27'h1000000}; vecB[1] = {1'b0, 6'h1F, 27'h1000001};
      vecDiff[1] = 3'd1; vecSat[1] = 1'b0;
      expRes[1] = vecA[1]; expMan[1] = 31'h08800001; expMask[1] = 8'h9E;
      // saturated subtract, sign follows a
      vecA[2] = {1'b1, 6'h20, 27'h1000000}; vecB[2] = {1'b0, 6'h10, 27'h0000005};
      vecDiff[2] = 3'd0; vecSat[2] = 1'b1;
      expRes[2] = vecA[2]; expMan[2] = 31'h07FFFFFF; expMask[2] = 8'h80;
      // exact cancel forces positive sign
      vecA[3] = {1'b1, 6'h10, 27'h2345678}; vecB[3] = {1'b0, 6'h10, 27'h2345678};
      vecDiff[3] = 3'd0; vecSat[3] = 1'b0;
      expRes[3] = {1'b0, 6'h10, 27'h2345678}; expMan[3] = 31'h0; expMask[3] = 8'hFF;
      // Inf - Inf gives canonical NaN
      vecA[4] = {1'b0, 6'h3F, 27'h0}; vecB[4] = {1'b1, 6'h3F, 27'h0};
      vecDiff[4] = 3'd0; vecSat[4] = 1'b0;
      expRes[4] = {1'b0, 6'h3F, 27'h4000000}; expMan[4] = 31'h0; expMask[4] = 8'hFF;
      // Inf + finite
      vecA[5] = {1'b1, 6'h3F, 27'h0}; vecB[5] = {1'b0, 6'h10, 27'h0000123};
      vecDiff[5] = 3'd0; vecSat[5] = 1'b1;
      expRes[5] = vecA[5]; expMan[5] = 31'h0; expMask[5] = 8'hFF;
      // NaN in a propagates unchanged
      vecA[6] = {1'b0, 6'h3F, 27'h0000001}; vecB[6] = {1'b1, 6'h3F, 27'h0};
      vecDiff[6] = 3'd0; vecSat[6] = 1'b0;
      expRes[6] = vecA[6]; expMan[6] = 31'h0; expMask[6] = 8'hFF;
      // five-nibble shift through the upper alignment path
      vecA[7] = {1'b0, 6'h20, 27'h1000000}; vecB[7] = {1'b0, 6'h1B, 27'h7654321};
      vecDiff[7] = 3'd5; vecSat[7] = 1'b0;
      expRes[7] = vecA[7]; expMan[7] = 31'h080003B3; expMask[7] = 8'hB8;
      // two-nibble shift, subtract
      vecA[8] = {1'b1, 6'h20, 27'h4000000}; vecB[8] = {1'b0, 6'h1E, 27'h1234567};
      vecDiff[8] = 3'd2; vecSat[8] = 1'b0;
      expRes[8] = vecA[8]; expMan[8] = 31'h1FF6E5D5; expMask[8] = 8'h00;
      // three-nibble shift, no sticky
      vecA[9] = {1'b0, 6'h20, 27'h1000000}; vecB[9] = {1'b0, 6'h1D, 27'h1000000};
      vecDiff[9] = 3'd3; vecSat[9] = 1'b0;
      expRes[9] = vecA[9]; expMan[9] = 31'h08008000; expMask[9] = 8'hB7;
   end

   // Main sequence: reset, stream all vectors, then reset mid-stream.
   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 34'h0, 34'h0, 3'd0, 1'b0);
      repeat (3) @(negedge clock);
      checkCleared("reset");
      rst = 1'b0;

      for (int c = 0; c < N + LAT; c++) begin
         @(negedge clock);
         if (c >= LAT) checkVector(c - LAT);
         else checkOutput($sformatf("prestream valid c%0d", c), 64'(outValid), 64'(1'b0));
         if (c < N) applyStimulus(1'b1, vecA[c], vecB[c], vecDiff[c], vecSat[c]);
         else applyStimulus(1'b0, 34'h0, 34'h0, 3'd0, 1'b0);
      end
      @(negedge clock);
      checkOutput("idle valid", 64'(outValid), 64'(1'b0));

      applyStimulus(1'b1, vecA[0], vecB[0], vecDiff[0], vecSat[0]);
      @(negedge clock);
      applyStimulus(1'b1, vecA[1], vecB[1], vecDiff[1], vecSat[1]);
      @(negedge clock);
      applyStimulus(1'b1, vecA[2], vecB[2], vecDiff[2], vecSat[2]);
      rst = 1'b1;
      @(negedge clock);
      checkCleared("midreset");
      rst = 1'b0;
      applyStimulus(1'b0, 34'h0, 34'h0, 3'd0, 1'b0);
      for (int k = 0; k <= LAT; k++) begin
         @(negedge clock);
         checkOutput($sformatf("flushed valid k%0d", k), 64'(outValid), 64'(1'b0));
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
